// File: rtl/bus_ctrl_arbiter_pkg.sv
// Shared definitions for the bus_ctrl arbiter slice: default geometry, limits,
// FSM state encoding and the index-width helper used by every file.
package bus_ctrl_pkg;

    localparam int NUM_CPUS         = 2;
    localparam int BLOCK_SIZE_WORDS = 2;
    localparam int WORD_W           = 32;
    localparam int STARVE_LIMIT     = 25;
    localparam int L2_TIMEOUT       = 10000;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CPU_IDX_W = idx_width(NUM_CPUS);
    localparam int BEAT_W    = idx_width(BLOCK_SIZE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_ctrl_arbiter_if.sv
// Requester/L2 side signal bundle of the arbiter. The arbiter takes the slave
// view; the cache interfaces and the L2 port model take the master view.
interface bus_ctrl_arbiter_if #(
    parameter int NUM_CPUS         = bus_ctrl_pkg::NUM_CPUS,
    parameter int BLOCK_SIZE_WORDS = bus_ctrl_pkg::BLOCK_SIZE_WORDS
);

    localparam int IDX_W  = bus_ctrl_pkg::idx_width(NUM_CPUS);
    localparam int BEAT_W = bus_ctrl_pkg::idx_width(BLOCK_SIZE_WORDS);

    logic [NUM_CPUS-1:0] req;
    logic [NUM_CPUS-1:0] req_wen;
    logic                l2_ready;

    logic [NUM_CPUS-1:0] gnt;
    logic [IDX_W-1:0]    gnt_id;
    logic                l2_req;
    logic                l2_wen;
    logic [BEAT_W-1:0]   beat_idx;
    logic [NUM_CPUS-1:0] beat_ack;
    logic [NUM_CPUS-1:0] xfer_done;
    logic [NUM_CPUS-1:0] starve;
    logic                l2_err;

    modport master (
        output req, req_wen, l2_ready,
        input  gnt, gnt_id, l2_req, l2_wen, beat_idx,
               beat_ack, xfer_done, starve, l2_err
    );

    modport slave (
        input  req, req_wen, l2_ready,
        output gnt, gnt_id, l2_req, l2_wen, beat_idx,
               beat_ack, xfer_done, starve, l2_err
    );

endinterface

// File: rtl/bus_ctrl_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward
// from rr_ptr with wrap-around.
module rr_picker #(
    parameter int NUM_CPUS = bus_ctrl_pkg::NUM_CPUS,
    parameter int IDX_W    = bus_ctrl_pkg::idx_width(NUM_CPUS)
) (
    input  logic [NUM_CPUS-1:0] req,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [IDX_W-1:0]    winner,
    output logic                valid
);

    logic [IDX_W-1:0] scan_idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        winner   = '0;
        valid    = 1'b0;
        scan_idx = '0;
        for (int k = NUM_CPUS - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_ptr) + k) % NUM_CPUS);
            if (req[scan_idx]) begin
                valid  = 1'b1;
                winner = scan_idx;
            end
        end
    end

endmodule

// File: rtl/bus_ctrl_arbiter.sv
// Round-robin owner of the shared L2 port: grants one requester per block,
// sequences its beats, and tracks requester starvation and L2 timeouts.
module bus_ctrl_arbiter #(
    parameter int NUM_CPUS         = bus_ctrl_pkg::NUM_CPUS,
    parameter int BLOCK_SIZE_WORDS = bus_ctrl_pkg::BLOCK_SIZE_WORDS,
    parameter int STARVE_LIMIT     = bus_ctrl_pkg::STARVE_LIMIT,
    parameter int L2_TIMEOUT       = bus_ctrl_pkg::L2_TIMEOUT
) (
    input logic               CLK,
    input logic               nRST,
    bus_ctrl_arbiter_if.slave bus
);

    import bus_ctrl_pkg::*;

    localparam int IDX_W  = idx_width(NUM_CPUS);
    localparam int BEAT_W = idx_width(BLOCK_SIZE_WORDS);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W  = $clog2(L2_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_XFER = XFER;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state_q,     state_d;
    logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [NUM_CPUS-1:0] gnt_q,       gnt_d;
    logic [IDX_W-1:0]    gnt_id_q,    gnt_id_d;
    logic                l2_wen_q,    l2_wen_d;
    logic [BEAT_W-1:0]   beat_idx_q,  beat_idx_d;
    logic [NUM_CPUS-1:0] xfer_done_q, xfer_done_d;
    logic [NUM_CPUS-1:0] starve_q,    starve_d;
    logic [WAIT_W-1:0]   wait_cnt_q [NUM_CPUS];
    logic [WAIT_W-1:0]   wait_cnt_d [NUM_CPUS];
    logic [TMO_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
    logic                l2_err_q,    l2_err_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                beat_accept;
    logic                last_beat;

    rr_picker #(
        .NUM_CPUS (NUM_CPUS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign beat_accept = (state_q == ST_XFER) && bus.l2_ready;
    assign last_beat   = (beat_idx_q == BEAT_W'(BLOCK_SIZE_WORDS - 1));

    // Grant FSM. The DONE cycle drops the grant and advances rr_ptr past the
    // owner, which also guarantees an IDLE cycle between transfers.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        l2_wen_d    = l2_wen_q;
        beat_idx_d  = beat_idx_q;
        xfer_done_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_XFER;
                    gnt_d      = NUM_CPUS'(1) << pick_idx;
                    gnt_id_d   = pick_idx;
                    l2_wen_d   = bus.req_wen[pick_idx];
                    beat_idx_d = '0;
                end
            end
            ST_XFER: begin
                if (beat_accept) begin
                    if (last_beat) begin
                        state_d     = ST_DONE;
                        beat_idx_d  = '0;
                        gnt_d       = '0;
                        xfer_done_d = gnt_q;
                        rr_ptr_d    = (gnt_id_q == IDX_W'(NUM_CPUS - 1)) ?
                                      '0 : gnt_id_q + IDX_W'(1);
                    end else begin
                        beat_idx_d = beat_idx_q + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Wait counters restart whenever a requester is idle or owns the bus.
    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            wait_cnt_d[i] = '0;
            if (bus.req[i] && !gnt_q[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_W'(STARVE_LIMIT)) ?
                                wait_cnt_q[i] : wait_cnt_q[i] + WAIT_W'(1);
            end
            starve_d[i] = (wait_cnt_d[i] == WAIT_W'(STARVE_LIMIT));
        end
    end

    // The FSM never abandons a stalled transfer; the error is only reported.
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == ST_XFER) && !bus.l2_ready) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_W'(L2_TIMEOUT)) ?
                        tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
        end
        l2_err_d = l2_err_q || (tmo_cnt_d == TMO_W'(L2_TIMEOUT));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            l2_wen_q    <= 1'b0;
            beat_idx_q  <= '0;
            xfer_done_q <= '0;
            starve_q    <= '0;
            tmo_cnt_q   <= '0;
            l2_err_q    <= 1'b0;
            for (int i = 0; i < NUM_CPUS; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            l2_wen_q    <= l2_wen_d;
            beat_idx_q  <= beat_idx_d;
            xfer_done_q <= xfer_done_d;
            starve_q    <= starve_d;
            tmo_cnt_q   <= tmo_cnt_d;
            l2_err_q    <= l2_err_d;
            for (int i = 0; i < NUM_CPUS; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.l2_req    = (state_q == ST_XFER);
    assign bus.l2_wen    = l2_wen_q;
    assign bus.beat_idx  = beat_idx_q;
    assign bus.beat_ack  = beat_accept ? gnt_q : '0;
    assign bus.xfer_done = xfer_done_q;
    assign bus.starve    = starve_q;
    assign bus.l2_err    = l2_err_q;

endmodule
